// File: rtl/gbus_arbiter.sv
// gbus_arbiter: two-master arbiter for a single generic-bus target.
// Port 0 is the CPU master and port 1 is the JTAG AHB access point.
// Ownership lasts for exactly one transfer. Grants are registered, so every
// grant is followed by a one-cycle IDLE bubble before the next arbitration.
module gbus_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int DBG_PRIORITY = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              AFT_CLK,
  input  logic              TRST,
  input  logic              m0_ren,
  input  logic              m0_wen,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [3:0]        m0_byte_en,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_busy,
  input  logic              m1_ren,
  input  logic              m1_wen,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [3:0]        m1_byte_en,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_busy,
  output logic              s_ren,
  output logic              s_wen,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic [3:0]        s_byte_en,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_busy,
  output logic [1:0]        grant
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  state_t     r_state;
  logic [1:0] r_grant;
  logic       r_last_served;
  logic [7:0] r_starve_cnt;

  logic w_req0;
  logic w_req1;
  logic w_pick1;
  logic w_enter0;
  logic w_enter1;

  assign w_req0 = m0_ren | m0_wen;
  assign w_req1 = m1_ren | m1_wen;
  assign grant  = r_grant;

  // Contention winner: debug port unless port 0 has starved, else alternate
  always_comb begin
    if (DBG_PRIORITY != 0) begin
      w_pick1 = (r_starve_cnt != LIMIT);
    end else begin
      w_pick1 = ~r_last_served;
    end
  end

  // Which owner state IDLE moves into this cycle, if any
  always_comb begin
    w_enter0 = 1'b0;
    w_enter1 = 1'b0;
    if (r_state == ST_IDLE) begin
      if (w_req0 && w_req1) begin
        w_enter1 = w_pick1;
        w_enter0 = ~w_pick1;
      end else begin
        w_enter0 = w_req0;
        w_enter1 = w_req1;
      end
    end
  end

  // Ownership FSM with registered grant, fairness history and starvation counter
  always_ff @(posedge AFT_CLK) begin
    if (TRST) begin
      r_state       <= ST_IDLE;
      r_grant       <= 2'b00;
      r_last_served <= 1'b0;
      r_starve_cnt  <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_enter0) begin
            r_state <= ST_OWN0;
            r_grant <= 2'b01;
          end else if (w_enter1) begin
            r_state <= ST_OWN1;
            r_grant <= 2'b10;
          end
        end
        ST_OWN0: begin
          // Leave on completion or when the master abandons its request
          if (!w_req0 || !s_busy) begin
            r_state <= ST_IDLE;
            r_grant <= 2'b00;
            if (w_req0) begin
              r_last_served <= 1'b0;
            end
          end
        end
        ST_OWN1: begin
          if (!w_req1 || !s_busy) begin
            r_state <= ST_IDLE;
            r_grant <= 2'b00;
            if (w_req1) begin
              r_last_served <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= 2'b00;
        end
      endcase

      if (w_enter0) begin
        r_starve_cnt <= 8'd0;
      end else if (w_req0 && (r_state != ST_OWN0) && (r_starve_cnt < LIMIT)) begin
        r_starve_cnt <= r_starve_cnt + 8'd1;
      end
    end
  end

  // Route the owner's request to the target; the non-owner sees a stall
  always_comb begin
    s_ren     = 1'b0;
    s_wen     = 1'b0;
    s_addr    = '0;
    s_wdata   = '0;
    s_byte_en = 4'b0000;
    m0_busy   = 1'b1;
    m1_busy   = 1'b1;
    m0_rdata  = '0;
    m1_rdata  = '0;
    case (r_state)
      ST_OWN0: begin
        s_wen     = m0_wen;
        s_ren     = m0_ren & ~m0_wen;
        s_addr    = m0_addr;
        s_wdata   = m0_wdata;
        s_byte_en = m0_byte_en;
        m0_busy   = s_busy;
        m0_rdata  = s_rdata;
      end
      ST_OWN1: begin
        s_wen     = m1_wen;
        s_ren     = m1_ren & ~m1_wen;
        s_addr    = m1_addr;
        s_wdata   = m1_wdata;
        s_byte_en = m1_byte_en;
        m1_busy   = s_busy;
        m1_rdata  = s_rdata;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_gbus_arbiter.sv
// tb_gbus_arbiter: runs two arbiters, one with debug priority and one with
// round-robin, under randomized masters and target. Expectations come from a
// transaction-level ownership model and go into queues that a monitor drains.
module tb_gbus_arbiter;

  localparam int NCYC  = 2000;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic trst;
  always #5 clk = ~clk;

  logic        ren   [2][2];
  logic        wen   [2][2];
  logic [31:0] addr  [2][2];
  logic [31:0] wdata [2][2];
  logic [3:0]  be    [2][2];
  logic        sbusy  [2];
  logic [31:0] srdata [2];

  wire [31:0] w_rdata [2][2];
  wire        w_busy  [2][2];
  wire        w_sren  [2];
  wire        w_swen  [2];
  wire [31:0] w_saddr [2];
  wire [31:0] w_swdata[2];
  wire [3:0]  w_sbe   [2];
  wire [1:0]  w_grant [2];

  // Instance 0 uses debug priority with a short starvation limit, instance 1 round-robin
  for (genvar k = 0; k < 2; k++) begin : g_dut
    gbus_arbiter #(
      .ADDR_W(32), .DATA_W(32),
      .DBG_PRIORITY((k == 0) ? 1 : 0), .STARVE_LIMIT(LIMIT)
    ) dut (
      .AFT_CLK(clk), .TRST(trst),
      .m0_ren(ren[k][0]), .m0_wen(wen[k][0]), .m0_addr(addr[k][0]),
      .m0_wdata(wdata[k][0]), .m0_byte_en(be[k][0]),
      .m0_rdata(w_rdata[k][0]), .m0_busy(w_busy[k][0]),
      .m1_ren(ren[k][1]), .m1_wen(wen[k][1]), .m1_addr(addr[k][1]),
      .m1_wdata(wdata[k][1]), .m1_byte_en(be[k][1]),
      .m1_rdata(w_rdata[k][1]), .m1_busy(w_busy[k][1]),
      .s_ren(w_sren[k]), .s_wen(w_swen[k]), .s_addr(w_saddr[k]),
      .s_wdata(w_swdata[k]), .s_byte_en(w_sbe[k]),
      .s_rdata(srdata[k]), .s_busy(sbusy[k]),
      .grant(w_grant[k])
    );
  end

  typedef struct {
    int          k;
    logic [1:0]  grant;
    logic        sren;
    logic        swen;
    logic [31:0] saddr;
    logic [31:0] swdata;
    logic [3:0]  sbe;
    logic [1:0]  busy;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } exp_t;

  typedef struct {
    int          k;
    int          p;
    logic [31:0] rdata;
  } cpl_t;

  exp_t q_exp[$];
  cpl_t q_cpl[$];

  int checks = 0;
  int errors = 0;

  // Reference model: owner index (-1 = none), last served port, port-0 wait count
  int own  [2];
  int last [2];
  int wt   [2];
  bit act  [2][2];
  bit done [2][2];

  task automatic chk(input string nm, input int k, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t got %h want %h", nm, k, $time, act_v, exp_v);
    end
  endtask

  task automatic model_cycle(input int k);
    exp_t e;
    cpl_t c;
    bit   rq [2];
    int   o;
    int   nown;
    for (int p = 0; p < 2; p++) rq[p] = ren[k][p] | wen[k][p];
    o = own[k];
    e.k = k;
    e.grant = (o < 0) ? 2'b00 : ((o == 0) ? 2'b01 : 2'b10);
    e.sren = 1'b0; e.swen = 1'b0; e.saddr = '0; e.swdata = '0; e.sbe = '0;
    e.busy = 2'b11; e.rd0 = '0; e.rd1 = '0;
    if (o >= 0) begin
      e.swen   = wen[k][o];
      e.sren   = ren[k][o] & ~wen[k][o];
      e.saddr  = addr[k][o];
      e.swdata = wdata[k][o];
      e.sbe    = be[k][o];
      e.busy[o] = sbusy[k];
      if (o == 0) e.rd0 = srdata[k];
      else        e.rd1 = srdata[k];
    end
    q_exp.push_back(e);

    done[k][0] = 1'b0;
    done[k][1] = 1'b0;
    if (o >= 0 && !sbusy[k]) begin
      c.k = k; c.p = o; c.rdata = srdata[k];
      q_cpl.push_back(c);
      done[k][o] = rq[o];
    end

    if (trst) begin
      own[k] = -1; last[k] = 0; wt[k] = 0;
    end else begin
      nown = o;
      if (o < 0) begin
        if (rq[0] && rq[1]) begin
          if (k == 0) nown = (wt[k] == LIMIT) ? 0 : 1;
          else        nown = (last[k] == 0) ? 1 : 0;
        end else if (rq[0]) nown = 0;
        else if (rq[1])     nown = 1;
      end else if (!rq[o]) begin
        nown = -1;
      end else if (!sbusy[k]) begin
        nown = -1;
        last[k] = o;
      end
      if (nown == 0 && o != 0)  wt[k] = 0;
      else if (rq[0] && o != 0) wt[k] = (wt[k] < LIMIT) ? wt[k] + 1 : LIMIT;
      own[k] = nown;
    end
  endtask

  // Stimulus: randomized masters and target, phased for contention, waits, aborts, resets
  initial begin
    int ph;
    int sel;
    trst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      own[k] = -1; last[k] = 0; wt[k] = 0;
      sbusy[k] = 1'b1; srdata[k] = '0;
      for (int p = 0; p < 2; p++) begin
        ren[k][p] = 1'b0; wen[k][p] = 1'b0; addr[k][p] = '0;
        wdata[k][p] = '0; be[k][p] = '0;
        act[k][p] = 1'b0; done[k][p] = 1'b0;
      end
    end
    repeat (2) @(posedge clk);
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      ph = (c / 250) % 4;
      trst = (ph == 3) && ($urandom_range(0, 39) == 0);
      for (int k = 0; k < 2; k++) begin
        for (int p = 0; p < 2; p++) begin
          if (act[k][p] && done[k][p]) act[k][p] = 1'b0;
          if (act[k][p] && (ph == 1 || ph == 3) && $urandom_range(0, 19) == 0) act[k][p] = 1'b0;
          if (!act[k][p] && (ph == 0 || ph == 2 || $urandom_range(0, 99) < 30)) begin
            act[k][p] = 1'b1;
            sel = $urandom_range(0, 3);
            ren[k][p]   = (sel == 0) || (sel == 2);
            wen[k][p]   = (sel != 0);
            addr[k][p]  = $urandom;
            wdata[k][p] = $urandom;
            be[k][p]    = (ph == 0) ? 4'b1111 : 4'($urandom);
          end
          if (!act[k][p]) begin
            ren[k][p] = 1'b0;
            wen[k][p] = 1'b0;
          end
        end
        sbusy[k]  = (ph == 0) ? 1'b0 : ($urandom_range(0, 99) < ((ph == 2) ? 60 : 50));
        srdata[k] = $urandom;
        model_cycle(k);
      end
    end
    @(negedge clk);
    #1;
    chk("cycle_queue_drained", 0, 32'(q_exp.size()), 32'd0);
    chk("completion_queue_drained", 0, 32'(q_cpl.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Monitor: per-cycle outputs, plus a completion stream whenever a master sees busy low
  initial begin
    exp_t e;
    cpl_t c;
    forever begin
      @(negedge clk);
      while (q_exp.size() > 0) begin
        e = q_exp.pop_front();
        chk("grant",    e.k, 32'(w_grant[e.k]),    32'(e.grant));
        chk("s_ren",    e.k, 32'(w_sren[e.k]),     32'(e.sren));
        chk("s_wen",    e.k, 32'(w_swen[e.k]),     32'(e.swen));
        chk("s_addr",   e.k, w_saddr[e.k],         e.saddr);
        chk("s_wdata",  e.k, w_swdata[e.k],        e.swdata);
        chk("s_byte_en",e.k, 32'(w_sbe[e.k]),      32'(e.sbe));
        chk("m0_busy",  e.k, 32'(w_busy[e.k][0]),  32'(e.busy[0]));
        chk("m1_busy",  e.k, 32'(w_busy[e.k][1]),  32'(e.busy[1]));
        chk("m0_rdata", e.k, w_rdata[e.k][0],      e.rd0);
        chk("m1_rdata", e.k, w_rdata[e.k][1],      e.rd1);
      end
      for (int k = 0; k < 2; k++) begin
        for (int p = 0; p < 2; p++) begin
          if (w_busy[k][p] === 1'b0) begin
            if (q_cpl.size() == 0) begin
              chk("unexpected_done", k, 32'(p), 32'hFFFF_FFFF);
            end else begin
              c = q_cpl.pop_front();
              chk("done_inst", k, 32'(k), 32'(c.k));
              chk("done_port", k, 32'(p), 32'(c.p));
              chk("done_rdata", k, w_rdata[k][p], c.rdata);
            end
          end
        end
      end
    end
  end

endmodule
